// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access
//  Brief    : MEM pipeline stage. It issues data-bus requests and stalls the
//             upstream stages until the bus acknowledges. It aligns and extends
//             load data, resolves branches and drives the MEM/WB register.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access (
  input  logic        clk,
  input  logic        rst,
  // pipeline control
  input  logic        keep,
  input  logic        nop,
  // EX/MEM register
  input  logic [31:0] ALU_co_pype,
  input  logic [31:0] read_data2_pype2,
  input  logic [4:0]  WReg_pype2,
  input  logic        RegWrite_pype2,
  input  logic [1:0]  MemtoReg_pype2,
  input  logic [1:0]  MemRW_pype2,
  input  logic [2:0]  funct3_pype2,
  input  logic [31:0] PCp4_pype2,
  input  logic [31:0] PCBranch_pype2,
  input  logic [2:0]  MemBranch_pype2,
  // data bus
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  // control
  output logic        mem_stall,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  // MEM/WB register
  output logic [31:0] read_data_pype3,
  output logic [31:0] ALU_co_pype3,
  output logic [31:0] PCp4_pype3,
  output logic [4:0]  WReg_pype3,
  output logic        RegWrite_pype3,
  output logic [1:0]  MemtoReg_pype3,
  output logic        misalign_pype3
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        w_rw_op, w_misalign, w_mem_op, w_is_load;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_addr, w_lane, w_load_ext;
  logic        bus_we_q;
  logic [3:0]  bus_be_q;
  logic [31:0] bus_addr_q, bus_wdata_q;
  logic        w_unused;

  // MemBranch bit2 carries no meaning in this stage
  assign w_unused = MemBranch_pype2[2];

  assign w_rw_op   = (MemRW_pype2 == 2'b01) || (MemRW_pype2 == 2'b10);
  assign w_mem_op  = w_rw_op && !w_misalign;
  assign w_is_load = (MemRW_pype2 == 2'b01) && !w_misalign;
  assign w_addr    = {ALU_co_pype[31:2], 2'b00};

  // Misalignment: half needs an even address, word (and wider codes) needs a 4-byte boundary
  always_comb begin
    w_misalign = 1'b0;
    if (funct3_pype2[1])
      w_misalign = w_rw_op && (ALU_co_pype[1:0] != 2'b00);
    else if (funct3_pype2[0])
      w_misalign = w_rw_op && ALU_co_pype[0];
  end

  // Byte enables and lane-replicated store data
  always_comb begin
    case (funct3_pype2[1:0])
      2'b00: begin
        w_be    = 4'b0001 << ALU_co_pype[1:0];
        w_wdata = {4{read_data2_pype2[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {ALU_co_pype[1], 1'b0};
        w_wdata = {2{read_data2_pype2[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = read_data2_pype2;
      end
    endcase
  end

  // Load data: move the addressed lane to bit 0, then sign/zero extend
  assign w_lane = dmem_rdata >> {ALU_co_pype[1:0], 3'b000};
  always_comb begin
    case (funct3_pype2)
      3'b000:  w_load_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load_ext = {24'd0, w_lane[7:0]};
      3'b101:  w_load_ext = {16'd0, w_lane[15:0]};
      default: w_load_ext = w_lane;
    endcase
  end

  // Branch resolution: the ALU result already holds the compare outcome
  always_comb begin
    branch_taken = 1'b0;
    if (MemBranch_pype2[1]) begin
      branch_taken = 1'b1;
    end else if (MemBranch_pype2[0]) begin
      case (funct3_pype2)
        3'b000:         branch_taken = (ALU_co_pype == 32'd0);
        3'b001:         branch_taken = (ALU_co_pype != 32'd0);
        3'b100, 3'b110: branch_taken = (ALU_co_pype == 32'd1);
        3'b101, 3'b111: branch_taken = (ALU_co_pype == 32'd0);
        default:        branch_taken = 1'b0;
      endcase
    end
  end
  assign branch_target = PCBranch_pype2;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: a request leaves IDLE, an ack returns from BUSY
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_mem_op) state_d = S_BUSY;
      default: if (dmem_ack) state_d = S_IDLE;
    endcase
  end

  // FSM outputs: IDLE drives the bus from the live inputs, BUSY from the latched copy
  always_comb begin
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = w_addr;
    dmem_wdata = w_wdata;
    dmem_be    = 4'b0000;
    mem_stall  = 1'b0;
    if (!rst) begin
      if (state_q == S_IDLE) begin
        if (w_mem_op) begin
          dmem_req  = 1'b1;
          dmem_we   = (MemRW_pype2 == 2'b10);
          dmem_be   = w_be;
          mem_stall = 1'b1;
        end
      end else begin
        dmem_req   = 1'b1;
        dmem_we    = bus_we_q;
        dmem_addr  = bus_addr_q;
        dmem_wdata = bus_wdata_q;
        dmem_be    = bus_be_q;
        mem_stall  = !dmem_ack;
      end
    end
  end

  // Latch the bus request on issue so it stays stable while BUSY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_we_q    <= 1'b0;
      bus_be_q    <= 4'b0000;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
    end else if (state_q == S_IDLE && w_mem_op) begin
      bus_we_q    <= (MemRW_pype2 == 2'b10);
      bus_be_q    <= w_be;
      bus_addr_q  <= w_addr;
      bus_wdata_q <= w_wdata;
    end
  end

  // MEM/WB register: stall and keep hold, nop bubbles, otherwise capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data_pype3 <= 32'd0;
      ALU_co_pype3    <= 32'd0;
      PCp4_pype3      <= 32'd0;
      WReg_pype3      <= 5'd0;
      RegWrite_pype3  <= 1'b0;
      MemtoReg_pype3  <= 2'd0;
      misalign_pype3  <= 1'b0;
    end else if (mem_stall || keep) begin
      read_data_pype3 <= read_data_pype3;
    end else if (nop) begin
      read_data_pype3 <= 32'd0;
      ALU_co_pype3    <= 32'd0;
      PCp4_pype3      <= 32'd0;
      WReg_pype3      <= 5'd0;
      RegWrite_pype3  <= 1'b0;
      MemtoReg_pype3  <= 2'd0;
      misalign_pype3  <= 1'b0;
    end else begin
      read_data_pype3 <= w_is_load ? w_load_ext : 32'd0;
      ALU_co_pype3    <= ALU_co_pype;
      PCp4_pype3      <= PCp4_pype2;
      WReg_pype3      <= WReg_pype2;
      RegWrite_pype3  <= RegWrite_pype2 && !w_misalign;
      MemtoReg_pype3  <= MemtoReg_pype2;
      misalign_pype3  <= w_misalign;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access
//  Brief    : Self-checking bench for mem_access. It compares against a
//             transaction-level reference model and uses a bus responder with
//             random latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        keep, nop;
  logic [31:0] ALU_co_pype, read_data2_pype2, PCp4_pype2, PCBranch_pype2;
  logic [4:0]  WReg_pype2;
  logic        RegWrite_pype2;
  logic [1:0]  MemtoReg_pype2, MemRW_pype2;
  logic [2:0]  funct3_pype2, MemBranch_pype2;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_stall, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] read_data_pype3, ALU_co_pype3, PCp4_pype3;
  logic [4:0]  WReg_pype3;
  logic        RegWrite_pype3, misalign_pype3;
  logic [1:0]  MemtoReg_pype3;

  int n_total = 0;
  int n_bad   = 0;

  // expected MEM/WB contents
  logic [31:0] e_rd, e_alu, e_pc;
  logic [4:0]  e_wr;
  logic        e_rw, e_mis;
  logic [1:0]  e_m2r;

  mem_access dut (
    .clk(clk), .rst(rst), .keep(keep), .nop(nop),
    .ALU_co_pype(ALU_co_pype), .read_data2_pype2(read_data2_pype2),
    .WReg_pype2(WReg_pype2), .RegWrite_pype2(RegWrite_pype2),
    .MemtoReg_pype2(MemtoReg_pype2), .MemRW_pype2(MemRW_pype2),
    .funct3_pype2(funct3_pype2), .PCp4_pype2(PCp4_pype2),
    .PCBranch_pype2(PCBranch_pype2), .MemBranch_pype2(MemBranch_pype2),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .read_data_pype3(read_data_pype3), .ALU_co_pype3(ALU_co_pype3),
    .PCp4_pype3(PCp4_pype3), .WReg_pype3(WReg_pype3),
    .RegWrite_pype3(RegWrite_pype3), .MemtoReg_pype3(MemtoReg_pype3),
    .misalign_pype3(misalign_pype3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1])      return 4;
    else if (f3[0]) return 2;
    else            return 1;
  endfunction

  function automatic int acc_lane(input logic [2:0] f3, input logic [31:0] a);
    if (acc_size(f3) == 4) return 0;
    return int'(a[1:0]);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be;
    int sz, ln;
    sz = acc_size(f3);
    ln = acc_lane(f3, a);
    for (int i = 0; i < 4; i++) be[i] = (i >= ln) && (i < ln + sz);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    int sz;
    sz = acc_size(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] v;
    int sz, ln;
    sz = acc_size(f3);
    ln = acc_lane(f3, a);
    v  = 32'd0;
    for (int j = 0; j < sz; j++) v[8*j +: 8] = rd[8*(ln+j) +: 8];
    if (!f3[2] && sz < 4 && v[8*sz-1])
      for (int j = sz; j < 4; j++) v[8*j +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic model_branch(input logic [2:0] mb, input logic [2:0] f3,
                                        input logic [31:0] alu);
    if (mb[1])  return 1'b1;
    if (!mb[0]) return 1'b0;
    case (f3)
      3'b000:         return alu == 0;
      3'b001:         return alu != 0;
      3'b100, 3'b110: return alu == 1;
      3'b101, 3'b111: return alu == 0;
      default:        return 1'b0;
    endcase
  endfunction

  task automatic set_op(input logic [1:0] rw, input logic [2:0] f3, input logic [31:0] alu,
                        input logic [31:0] d2, input logic [2:0] mb, input logic [4:0] wr,
                        input logic rwe, input logic k, input logic n);
    MemRW_pype2      = rw;
    funct3_pype2     = f3;
    ALU_co_pype      = alu;
    read_data2_pype2 = d2;
    MemBranch_pype2  = mb;
    WReg_pype2       = wr;
    RegWrite_pype2   = rwe;
    keep             = k;
    nop              = n;
    MemtoReg_pype2   = 2'($urandom);
    PCp4_pype2       = $urandom;
    PCBranch_pype2   = $urandom;
  endtask

  task automatic chk_memwb();
    chk("wb_rdata", read_data_pype3, e_rd);
    chk("wb_alu",   ALU_co_pype3,    e_alu);
    chk("wb_pc4",   PCp4_pype3,      e_pc);
    chk("wb_wreg",  {27'd0, WReg_pype3}, {27'd0, e_wr});
    chk("wb_regw",  {31'd0, RegWrite_pype3}, {31'd0, e_rw});
    chk("wb_m2r",   {30'd0, MemtoReg_pype3}, {30'd0, e_m2r});
    chk("wb_mis",   {31'd0, misalign_pype3}, {31'd0, e_mis});
  endtask

  // Called just after a rising edge with the instruction already on the inputs;
  // returns just after the edge at which the instruction leaves the stage.
  task automatic run_op(input int lat, input logic [31:0] rdata);
    int          sz, stalls;
    logic        rwop, mis, mop, st;
    logic [31:0] alu;
    alu    = ALU_co_pype;
    sz     = acc_size(funct3_pype2);
    rwop   = (MemRW_pype2 == 2'b01) || (MemRW_pype2 == 2'b10);
    st     = (MemRW_pype2 == 2'b10);
    mis    = rwop && ((int'(alu[1:0]) % sz) != 0);
    mop    = rwop && !mis;
    stalls = 0;
    @(negedge clk);
    chk("br_taken",  {31'd0, branch_taken},
        {31'd0, model_branch(MemBranch_pype2, funct3_pype2, alu)});
    chk("br_target", branch_target, PCBranch_pype2);
    chk("req",       {31'd0, dmem_req}, {31'd0, mop});
    if (mop) begin
      chk("we",   {31'd0, dmem_we}, {31'd0, st});
      chk("addr", dmem_addr, {alu[31:2], 2'b00});
      chk("be",   {28'd0, dmem_be}, {28'd0, model_be(funct3_pype2, alu)});
      if (st) chk("wdata", dmem_wdata, model_wdata(funct3_pype2, read_data2_pype2));
      if (mem_stall) stalls++;
      for (int c = 0; c <= lat; c++) begin
        @(posedge clk); #1;
        dmem_ack   = (c == lat);
        dmem_rdata = (c == lat) ? rdata : $urandom;
        @(negedge clk);
        chk("busy_req",  {31'd0, dmem_req}, 32'd1);
        chk("busy_we",   {31'd0, dmem_we}, {31'd0, st});
        chk("busy_addr", dmem_addr, {alu[31:2], 2'b00});
        chk("busy_be",   {28'd0, dmem_be}, {28'd0, model_be(funct3_pype2, alu)});
        if (mem_stall) stalls++;
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      chk("stall_cycles", stalls, 1 + lat);
    end else begin
      dmem_rdata = $urandom;
      chk("no_stall", {31'd0, mem_stall}, 32'd0);
      @(posedge clk); #1;
    end
    if (keep) begin
      // MEM/WB holds its previous contents
    end else if (nop) begin
      e_rd = 0; e_alu = 0; e_pc = 0; e_wr = 0; e_rw = 0; e_m2r = 0; e_mis = 0;
    end else begin
      e_rd  = (MemRW_pype2 == 2'b01 && !mis) ? model_load(funct3_pype2, alu, rdata) : 32'd0;
      e_alu = alu;
      e_pc  = PCp4_pype2;
      e_wr  = WReg_pype2;
      e_rw  = RegWrite_pype2 && !mis;
      e_m2r = MemtoReg_pype2;
      e_mis = mis;
    end
    chk_memwb();
  endtask

  initial begin
    logic [1:0]  rw;
    logic [2:0]  f3, mb;
    logic [31:0] alu, d2;
    int          sz;
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    set_op(2'b00, 3'd0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    e_rd = 0; e_alu = 0; e_pc = 0; e_wr = 0; e_rw = 0; e_m2r = 0; e_mis = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_be",  {28'd0, dmem_be}, 32'd0);
    chk_memwb();
    rst = 1'b0;

    // ALU op passes straight through in one cycle
    set_op(2'b00, 3'd0, 32'h1234, 32'd0, 3'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    run_op(0, 32'd0);
    chk("alu_pass", ALU_co_pype3, 32'h1234);

    // lb at 0x103, ack after 3 BUSY cycles
    set_op(2'b01, 3'b000, 32'h103, 32'd0, 3'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    run_op(3, 32'h80FF_FFFF);
    chk("lb_sext", read_data_pype3, 32'hFFFF_FF80);

    // sh at 0x202
    set_op(2'b10, 3'b001, 32'h202, 32'h0000_BEEF, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    run_op(2, 32'd0);

    // misaligned lw
    set_op(2'b01, 3'b010, 32'h101, 32'd0, 3'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    run_op(0, 32'd0);
    chk("lw_mis", {31'd0, misalign_pype3}, 32'd1);

    // bne taken / not taken
    set_op(2'b00, 3'b001, 32'h5, 32'd0, 3'b001, 5'd0, 1'b0, 1'b0, 1'b0);
    PCBranch_pype2 = 32'h80;
    run_op(0, 32'd0);
    set_op(2'b00, 3'b001, 32'h0, 32'd0, 3'b001, 5'd0, 1'b0, 1'b0, 1'b0);
    run_op(0, 32'd0);

    // reset during BUSY, then an ack that must not complete anything
    set_op(2'b01, 3'b010, 32'h40, 32'd0, 3'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_req", {31'd0, dmem_req}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    e_rd = 0; e_alu = 0; e_pc = 0; e_wr = 0; e_rw = 0; e_m2r = 0; e_mis = 0;
    chk("rstb_req", {31'd0, dmem_req}, 32'd0);
    chk("rstb_we",  {31'd0, dmem_we}, 32'd0);
    chk("rstb_be",  {28'd0, dmem_be}, 32'd0);
    chk_memwb();
    @(posedge clk); #1;
    rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("late_ack_stall", {31'd0, mem_stall}, 32'd1);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk_memwb();
    @(negedge clk);
    chk("reissue_stall", {31'd0, mem_stall}, 32'd1);
    @(posedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    e_rd = 32'h1234_5678; e_alu = 32'h40; e_pc = PCp4_pype2; e_wr = 5'd3;
    e_rw = 1'b1; e_m2r = MemtoReg_pype2; e_mis = 1'b0;
    chk_memwb();

    // randomized instruction stream
    for (int t = 0; t < 200; t++) begin
      rw  = 2'($urandom);
      f3  = 3'($urandom);
      mb  = 3'($urandom_range(0, 3));
      alu = $urandom;
      if (mb[0] && $urandom_range(0, 2) != 2) alu = 32'($urandom_range(0, 1));
      sz  = acc_size(f3);
      d2  = $urandom;
      if (sz == 1) d2 = d2 & 32'hFF;
      if (sz == 2) d2 = d2 & 32'hFFFF;
      set_op(rw, f3, alu, d2, mb, 5'($urandom), 1'($urandom),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      run_op($urandom_range(0, 4), $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
